xbar_output_arbiter: RTL and testbench

- Read-side scheduler for one crossbar output port. Owns the read/pop side of NUM_IN async FIFOs, one per crossbar input, all in the output clock domain.
- Picks one non-empty FIFO by round-robin and locks onto it for a whole packet, until a flit with the last flag is popped.
- Drives the selected FIFO's data onto a single valid/ready output channel.

---
 rtl/xbar_arb_pkg.sv | 16 +
 rtl/xbar_arb_if.sv | 27 ++
 rtl/xbar_output_arbiter_rr_priority_picker.sv | 29 ++
 rtl/xbar_output_arbiter.sv | 92 +++++++++
 tb/tb_xbar_output_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_arb_pkg.sv
// Shared types and helpers for the crossbar output-port arbiter.
package xbar_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int CNT_W = 16;

  // Explicit wrap so non-power-of-two port counts never land on a dead index.
  function automatic int unsigned next_rr_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/xbar_arb_if.sv
// FIFO read side plus valid/ready output channel of one crossbar output port.
interface xbar_arb_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 33,
  parameter int IDX_W  = $clog2(NUM_IN)
);

  logic [NUM_IN-1:0]        fifo_empty;
  logic [NUM_IN*DATA_W-1:0] fifo_rdata;
  logic [NUM_IN-1:0]        fifo_pop;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_src;
  logic                     busy;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_pop, out_valid, out_data, out_src, busy
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_pop, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/xbar_output_arbiter_rr_priority_picker.sv
// Rotating-priority search: first set request at or after rr_ptr, modulo N.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] cand;

  // Scan from the far end so the candidate closest to rr_ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/xbar_output_arbiter.sv
// Packet-locked round-robin read scheduler for one crossbar output port.
// Optional per-input packet counters: define XBAR_ARB_GRANT_CNT_EN.
module xbar_output_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int  NUM_IN   = 4,
  parameter int  DATA_W   = 33,
  parameter int  LAST_BIT = 32,
  localparam int IDX_W    = $clog2(NUM_IN)
) (
  input  logic                    clk_rx,
  input  logic                    rst_rx,
`ifdef XBAR_ARB_GRANT_CNT_EN
  input  logic                    cnt_clr,
  output logic [NUM_IN*CNT_W-1:0] grant_cnt,
`endif
  xbar_arb_if.master              bus
);

  arb_state_e        state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [NUM_IN-1:0] req;
  logic [DATA_W-1:0] head;
  logic              pop_fire;
  logic              last_pop;

  assign req = ~bus.fifo_empty;

  rr_priority_picker #(.N(NUM_IN), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Outputs are pure decodes of state/grant so an async reset clears them at once.
  assign head          = bus.fifo_rdata[int'(grant)*DATA_W +: DATA_W];
  assign bus.out_valid = (state == LOCKED) && !bus.fifo_empty[grant];
  assign bus.out_data  = head;
  assign bus.out_src   = grant;
  assign bus.busy      = (state == LOCKED);
  assign pop_fire      = bus.out_valid && bus.out_ready;
  assign last_pop      = pop_fire && head[LAST_BIT];
  assign bus.fifo_pop  = pop_fire ? ({{(NUM_IN-1){1'b0}}, 1'b1} << grant) : '0;

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (last_pop) begin
            state  <= IDLE;
            rr_ptr <= IDX_W'(next_rr_ptr(32'(grant), NUM_IN));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XBAR_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  // Clear has priority over a same-cycle packet completion.
  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (last_pop && (cnt_q[grant] != {CNT_W{1'b1}})) begin
      cnt_q[grant] <= cnt_q[grant] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Bench for xbar_output_arbiter: FIFO queues, packet-level reference model, directed and random traffic.
module tb_xbar_output_arbiter;
  import xbar_arb_pkg::*;

  localparam int NUM_IN   = 4;
  localparam int DATA_W   = 33;
  localparam int LAST_BIT = 32;
  localparam int IDX_W    = 2;

  logic clk_rx = 1'b0;
  logic rst_rx = 1'b1;
  always #5 clk_rx = ~clk_rx;

  xbar_arb_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

`ifdef XBAR_ARB_GRANT_CNT_EN
  logic                    cnt_clr = 1'b0;
  logic [NUM_IN*CNT_W-1:0] grant_cnt;
`endif

  xbar_output_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LAST_BIT(LAST_BIT)) dut (
    .clk_rx    (clk_rx),
    .rst_rx    (rst_rx),
`ifdef XBAR_ARB_GRANT_CNT_EN
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  logic [DATA_W-1:0] q [NUM_IN][$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int served[$];
  int pop_cyc[$];

  // Reference model: which input owns the port, and who has priority next.
  bit m_locked;
  int m_owner;
  int m_rr;

  logic              cap_valid, cap_busy;
  logic [NUM_IN-1:0] cap_pop;
  logic [DATA_W-1:0] cap_data;
  logic [IDX_W-1:0]  cap_src;

  typedef struct {
    bit                rdy;
    bit                valid;
    bit                busy;
    logic [NUM_IN-1:0] pop;
    int                src;
    logic [DATA_W-1:0] data;
  } vec_t;

  function automatic logic [DATA_W-1:0] flit(input bit last, input int tag);
    return {last, 32'(tag)};
  endfunction

  function automatic logic [DATA_W-1:0] filler(input int i);
    return {1'b0, 32'h5EED_0000 + 32'(i)};
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_IN; i++) n += q[i].size();
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NUM_IN; i++) begin
      bus.fifo_empty[i] = (q[i].size() == 0);
      bus.fifo_rdata[i*DATA_W +: DATA_W] = (q[i].size() != 0) ? q[i][0] : filler(i);
    end
  endtask

  task automatic push_pkt(input int i, input int len, input int tag);
    for (int k = 0; k < len; k++) q[i].push_back(flit(k == len - 1, tag + k));
    drive_fifos();
  endtask

  task automatic model_check(input bit rdy);
    bit ev;
    logic [NUM_IN-1:0] ep;
    ev = m_locked && (q[m_owner].size() != 0);
    ep = '0;
    if (ev && rdy) ep[m_owner] = 1'b1;
    chk("m_valid", 64'(bus.out_valid), 64'(ev));
    chk("m_busy", 64'(bus.busy), 64'(m_locked));
    chk("m_pop", 64'(bus.fifo_pop), 64'(ep));
    if (m_locked) chk("m_src", 64'(bus.out_src), 64'(m_owner));
    if (ev) chk("m_data", 64'(bus.out_data), 64'(q[m_owner][0]));
  endtask

  task automatic model_step(input bit rdy);
    int c;
    if (!m_locked) begin
      for (int k = 0; k < NUM_IN; k++) begin
        c = (m_rr + k) % NUM_IN;
        if (q[c].size() != 0) begin
          m_locked = 1'b1;
          m_owner  = c;
          break;
        end
      end
    end else if (rdy && q[m_owner].size() != 0) begin
      if (q[m_owner][0][LAST_BIT]) begin
        m_locked = 1'b0;
        m_rr     = (m_owner + 1) % NUM_IN;
      end
    end
  endtask

  // One clock: inputs settle mid-low phase, outputs sampled there, FIFOs pop after the edge.
  task automatic cycle(input bit rdy);
    logic [NUM_IN-1:0] pop_seen;
    @(negedge clk_rx);
    bus.out_ready = rdy;
    #1;
    model_check(rdy);
    cap_valid = bus.out_valid;
    cap_busy  = bus.busy;
    cap_pop   = bus.fifo_pop;
    cap_data  = bus.out_data;
    cap_src   = bus.out_src;
    pop_seen  = bus.fifo_pop;
    @(posedge clk_rx);
    model_step(rdy);
    #1;
    cyc++;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pop_seen[i]) begin
        served.push_back(i);
        pop_cyc.push_back(cyc);
        if (q[i].size() != 0) void'(q[i].pop_front());
      end
    end
    drive_fifos();
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (m_locked || pending() != 0); n++) cycle(1'b1);
    chk("drained", 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    rst_rx = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) q[i].delete();
    drive_fifos();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    @(posedge clk_rx);
    @(posedge clk_rx);
    #1;
    rst_rx = 1'b0;
  endtask

  vec_t t1[5];

  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) q[i].delete();
    drive_fifos();
    t1[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 0, flit(0, 0)};
    t1[1] = '{1'b1, 1'b1, 1'b1, 4'b0100, 2, flit(0, 'h200)};
    t1[2] = '{1'b1, 1'b1, 1'b1, 4'b0100, 2, flit(0, 'h201)};
    t1[3] = '{1'b1, 1'b1, 1'b1, 4'b0100, 2, flit(1, 'h202)};
    t1[4] = '{1'b1, 1'b0, 1'b0, 4'b0000, 0, flit(0, 0)};

    // Reset state, sampled while reset is still held.
    m_locked = 1'b0; m_owner = 0; m_rr = 0;
    @(posedge clk_rx);
    @(posedge clk_rx);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pop", 64'(bus.fifo_pop), 64'd0);
    chk("rst_src", 64'(bus.out_src), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'(filler(0)));
    rst_rx = 1'b0;

    // 3-flit packet on input 2, ready held high.
    push_pkt(2, 3, 'h200);
    for (int e = 0; e < 5; e++) begin
      cycle(t1[e].rdy);
      chk("t1_valid", 64'(cap_valid), 64'(t1[e].valid));
      chk("t1_busy", 64'(cap_busy), 64'(t1[e].busy));
      chk("t1_pop", 64'(cap_pop), 64'(t1[e].pop));
      if (t1[e].valid) begin
        chk("t1_src", 64'(cap_src), 64'(t1[e].src));
        chk("t1_data", 64'(cap_data), 64'(t1[e].data));
      end
    end
    // Priority now sits at 3: of inputs 0 and 3, input 3 goes first, then wrap to 0.
    push_pkt(0, 1, 'h300);
    push_pkt(3, 1, 'h310);
    cycle(1'b1);
    cycle(1'b1);
    chk("rr_after_2", 64'(cap_src), 64'd3);
    cycle(1'b1);
    cycle(1'b1);
    chk("rr_wrap_0", 64'(cap_src), 64'd0);

    // All four inputs with single-flit packets from rr_ptr = 0.
    do_reset();
    push_pkt(0, 1, 'h100);
    push_pkt(0, 1, 'h104);
    push_pkt(1, 1, 'h101);
    push_pkt(2, 1, 'h102);
    push_pkt(3, 1, 'h103);
    served.delete();
    pop_cyc.delete();
    drain(40);
    chk("t2_count", 64'(served.size()), 64'd5);
    for (int k = 0; k < 5 && k < served.size(); k++) chk("t2_order", 64'(served[k]), 64'(k % NUM_IN));
    for (int k = 1; k < pop_cyc.size(); k++) chk("t2_gap", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd2);

    // Granted input 1 runs dry mid-packet while input 0 waits.
    push_pkt(1, 1, 'h400);
    q[1][0][LAST_BIT] = 1'b0;
    drive_fifos();
    push_pkt(0, 1, 'h410);
    served.delete();
    cycle(1'b1);
    cycle(1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      chk("t3_gap_valid", 64'(cap_valid), 64'd0);
      chk("t3_gap_busy", 64'(cap_busy), 64'd1);
      chk("t3_gap_pop", 64'(cap_pop), 64'd0);
    end
    q[1].push_back(flit(0, 'h401));
    q[1].push_back(flit(1, 'h402));
    drive_fifos();
    drain(40);
    chk("t3_count", 64'(served.size()), 64'd4);
    for (int k = 0; k < 4 && k < served.size(); k++) chk("t3_order", 64'(served[k]), 64'(k < 3 ? 1 : 0));

    // Backpressure: ready low for 5 cycles with a flit on offer.
    push_pkt(2, 2, 'h500);
    cycle(1'b0);
    begin
      logic [DATA_W-1:0] d0;
      d0 = '0;
      for (int k = 0; k < 5; k++) begin
        cycle(1'b0);
        if (k == 0) d0 = cap_data;
        chk("t4_valid", 64'(cap_valid), 64'd1);
        chk("t4_pop", 64'(cap_pop), 64'd0);
        chk("t4_stable", 64'(cap_data), 64'(d0));
      end
      chk("t4_head", 64'(d0), 64'(flit(0, 'h500)));
    end
    cycle(1'b1);
    chk("t4_one_pop", 64'(cap_pop), 64'b0100);
    drain(20);

    // Asynchronous reset between edges in the middle of a packet.
    push_pkt(3, 3, 'h600);
    cycle(1'b1);
    cycle(1'b1);
    @(negedge clk_rx);
    bus.out_ready = 1'b1;
    #2;
    chk("t5_pre_busy", 64'(bus.busy), 64'd1);
    rst_rx = 1'b1;
    #1;
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_pop", 64'(bus.fifo_pop), 64'd0);
    for (int i = 0; i < NUM_IN; i++) q[i].delete();
    drive_fifos();
    m_locked = 1'b0; m_owner = 0; m_rr = 0;
    @(posedge clk_rx);
    @(posedge clk_rx);
    #1;
    rst_rx = 1'b0;
    push_pkt(1, 1, 'h700);
    push_pkt(3, 1, 'h710);
    served.delete();
    drain(20);
    chk("t5_rr_zero", 64'(served.size() != 0 ? served[0] : -1), 64'd1);

    // Random packet traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, NUM_IN - 1);
        if (q[i].size() < 8) push_pkt(i, $urandom_range(1, 4), $urandom);
      end
      cycle($urandom_range(0, 9) < 7);
    end
    drain(500);

`ifdef XBAR_ARB_GRANT_CNT_EN
    begin
      int pkts3;
      do_reset();
      cnt_clr = 1'b0;
      for (int i = 0; i < NUM_IN; i++) chk("cnt_rst", 64'(grant_cnt[i*CNT_W +: CNT_W]), 64'd0);
      pkts3 = 0;
      for (int n = 0; n < 150000 && pkts3 < 70000; n++) begin
        if (q[3].size() == 0) push_pkt(3, 1, n);
        served.delete();
        cycle(1'b1);
        if (served.size() != 0 && served[0] == 3) pkts3++;
      end
      chk("cnt_pkts", 64'(pkts3), 64'd70000);
      chk("cnt_sat", 64'(grant_cnt[3*CNT_W +: CNT_W]), 64'hFFFF);
      chk("cnt_other", 64'(grant_cnt[0 +: CNT_W]), 64'd0);
      drain(10);
      push_pkt(3, 1, 'h800);
      cycle(1'b1);
      cnt_clr = 1'b1;
      cycle(1'b1);
      chk("cnt_clr_pop", 64'(cap_pop), 64'b1000);
      cnt_clr = 1'b0;
      chk("cnt_clr_wins", 64'(grant_cnt[3*CNT_W +: CNT_W]), 64'd0);
      push_pkt(3, 1, 'h801);
      cycle(1'b1);
      cycle(1'b1);
      chk("cnt_after_clr", 64'(grant_cnt[3*CNT_W +: CNT_W]), 64'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
